// File: rtl/serial_image_loader.sv
// Serial image loader: receives 8N1 frames on rx_in and writes each byte into the data RAM
// at consecutive addresses, then hands the RAM over to the processor once the image is complete.
module serial_image_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 16,
    parameter int IMG_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              rx_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              frame_err,
    output logic              proc_select
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START_BIT,
        DATA,
        STOP,
        WRITE,
        DONE
    } state_t;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(IMG_BYTES - 1);

    state_t          state;
    state_t          next_state;
    logic            rx_meta;
    logic            rx_s;
    logic            armed;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [ADDR_W:0] count;
    logic            half_hit;
    logic            full_hit;
    logic            load_go;
    logic            write_go;
    logic            frame_bad;

    assign half_hit = (timer == HALF_M1);
    assign full_hit = (timer == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_go    = 1'b0;
        write_go   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (start_load) begin
                    next_state = WAIT_START;
                    load_go    = 1'b1;
                end
            end
            WAIT_START: begin
                if (!rx_s && armed) begin
                    next_state = START_BIT;
                end
            end
            START_BIT: begin
                if (half_hit) begin
                    next_state = rx_s ? WAIT_START : DATA;
                end
            end
            DATA: begin
                if (full_hit && (bit_cnt == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (full_hit) begin
                    if (rx_s) begin
                        next_state = WRITE;
                        write_go   = 1'b1;
                    end else begin
                        next_state = WAIT_START;
                        frame_bad  = 1'b1;
                    end
                end
            end
            WRITE: begin
                next_state = (count == LAST_CNT) ? DONE : WAIT_START;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A bad stop bit leaves the line low; armed blocks that low level from
    // being mistaken for a fresh start bit until the line has returned high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            frame_err   <= 1'b0;
            proc_select <= 1'b1;
            armed       <= 1'b1;
            timer       <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            count       <= '0;
        end else begin
            ram_we <= write_go;
            if (frame_bad) begin
                armed <= 1'b0;
            end else if (rx_s) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load_go) begin
                        count       <= '0;
                        frame_err   <= 1'b0;
                        load_done   <= 1'b0;
                        busy        <= 1'b1;
                        proc_select <= 1'b0;
                    end
                end
                WAIT_START: begin
                    timer <= '0;
                end
                START_BIT: begin
                    bit_cnt <= '0;
                    timer   <= half_hit ? '0 : timer + TW'(1);
                end
                DATA: begin
                    if (full_hit) begin
                        timer     <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (full_hit) begin
                        timer <= '0;
                        if (rx_s) begin
                            ram_addr  <= count[ADDR_W-1:0];
                            ram_wdata <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: begin
                    count <= count + 1'b1;
                end
                DONE: begin
                    load_done   <= 1'b1;
                    busy        <= 1'b0;
                    proc_select <= 1'b1;
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_image_loader.sv
// Self-checking bench for serial_image_loader: drives 8N1 frames and compares RAM writes
// and status flags against a queue-based model of the expected image contents.
module tb_serial_image_loader;

    localparam int CPB = 16;
    localparam int AW  = 2;
    localparam int NB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_load;
    logic          rx_in;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          busy;
    logic          load_done;
    logic          frame_err;
    logic          proc_select;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int model_count = 0;

    int got_addr[$];
    int got_data[$];
    int got_cyc[$];
    int exp_addr[$];
    int exp_data[$];

    serial_image_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .IMG_BYTES   (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .rx_in      (rx_in),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .load_done  (load_done),
        .frame_err  (frame_err),
        .proc_select(proc_select)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            got_addr.push_back(int'(ram_addr));
            got_data.push_back(int'(ram_wdata));
            got_cyc.push_back(cycle);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ram_we"}, 32'(ram_we), 0);
        check_output({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check_output({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
        check_output({tag, "_busy"}, 32'(busy), 0);
        check_output({tag, "_load_done"}, 32'(load_done), 0);
        check_output({tag, "_frame_err"}, 32'(frame_err), 0);
        check_output({tag, "_proc_select"}, 32'(proc_select), 1);
    endtask

    // Drives one frame; caller is positioned just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
        rx_in = stop_bit;
        tick(CPB);
        rx_in = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        exp_addr.push_back(model_count);
        exp_data.push_back(int'(b));
        model_count++;
        send_byte(b, 1'b1);
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        tick(1);
        start_load = 1'b0;
    endtask

    task automatic compare_writes(input string tag, input bit check_spacing);
        check_output({tag, "_write_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) begin
                check_output($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
                check_output($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
            end
        end
        if (check_spacing) begin
            for (int i = 1; i < got_cyc.size(); i++) begin
                check_output($sformatf("%s_spacing%0d", tag, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(10 * CPB));
            end
        end
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        logic [7:0] abort_byte;

        rst        = 1'b1;
        start_load = 1'b0;
        rx_in      = 1'b1;
        tick(3);
        check_reset_values("reset");

        start_load = 1'b1;
        tick(1);
        start_load = 1'b0;
        check_output("rst_over_start_busy", 32'(busy), 0);
        check_output("rst_over_start_psel", 32'(proc_select), 1);
        rst = 1'b0;
        tick(2);

        $display("[TB] load 1: fixed bytes");
        pulse_start();
        model_count = 0;
        check_output("load1_busy", 32'(busy), 1);
        check_output("load1_psel", 32'(proc_select), 0);
        check_output("load1_done_clear", 32'(load_done), 0);
        tick(4);
        apply_stimulus(8'h12);
        tick(4);
        apply_stimulus(8'h34);
        tick(4);
        apply_stimulus(8'h56);
        tick(4);
        apply_stimulus(8'h78);
        check_output("load1_done", 32'(load_done), 1);
        check_output("load1_busy_end", 32'(busy), 0);
        check_output("load1_psel_end", 32'(proc_select), 1);
        compare_writes("load1", 1'b0);
        check_output("hold_ram_we", 32'(ram_we), 0);
        check_output("hold_ram_addr", 32'(ram_addr), 3);
        check_output("hold_ram_wdata", 32'(ram_wdata), 32'h78);

        $display("[TB] load 2: glitch, framing error, start_load mid-frame");
        pulse_start();
        model_count = 0;
        check_output("load2_done_clear", 32'(load_done), 0);
        tick(4);
        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        tick(2 * CPB);
        check_output("glitch_frame_err", 32'(frame_err), 0);
        check_output("glitch_busy", 32'(busy), 1);
        check_output("glitch_no_write", 32'(got_addr.size()), 0);
        send_byte(8'hA5, 1'b0);
        tick(2 * CPB);
        check_output("bad_stop_frame_err", 32'(frame_err), 1);
        check_output("bad_stop_no_write", 32'(got_addr.size()), 0);
        apply_stimulus(8'h3C);
        tick(4);
        fork
            apply_stimulus(8'($urandom));
            begin
                tick(5 * CPB);
                pulse_start();
            end
        join
        check_output("mid_start_busy", 32'(busy), 1);
        tick(4);
        apply_stimulus(8'($urandom));
        tick(4);
        apply_stimulus(8'($urandom));
        check_output("load2_done", 32'(load_done), 1);
        check_output("load2_frame_err_sticky", 32'(frame_err), 1);
        compare_writes("load2", 1'b0);

        $display("[TB] load 3: reset during data bit 4 of second byte");
        pulse_start();
        model_count = 0;
        check_output("load3_frame_err_clear", 32'(frame_err), 0);
        check_output("load3_psel", 32'(proc_select), 0);
        tick(4);
        apply_stimulus(8'($urandom));
        tick(4);
        abort_byte = 8'($urandom);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_in = abort_byte[i];
            tick(CPB);
        end
        rx_in = abort_byte[4];
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        check_reset_values("mid_rst");
        rst   = 1'b0;
        rx_in = 1'b1;
        tick(12 * CPB);
        compare_writes("load3", 1'b0);

        $display("[TB] load 4: back-to-back random frames");
        pulse_start();
        model_count = 0;
        for (int i = 0; i < NB; i++) begin
            apply_stimulus(8'($urandom));
        end
        check_output("load4_done", 32'(load_done), 1);
        check_output("load4_busy_end", 32'(busy), 0);
        compare_writes("load4", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
